// File: rtl/trap_controller.sv
// Trap sequencer: captures SEPC/SCAUSE, flushes, redirects to the trap vector and returns on SRET.
// Optional nested-trap flag built only when TRAP_DOUBLE_FAULT_EN is defined.
module trap_controller #(
  parameter logic [14:0] TRAP_VECTOR   = 15'h1F00,
  parameter int unsigned FLUSH_CYCLES  = 2,
  parameter logic [14:0] RETURN_OFFSET = 15'd4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             exception_in,
  input  logic [14:0]      sepc_in,
  input  logic [63:0]      scause_in,
  input  logic             sret,
  output logic             flush,
  output logic             pc_redirect,
  output logic [14:0]      redirect_addr,
  output logic [14:0]      sepc_q,
  output logic [63:0]      scause_q,
  output logic             in_trap,
  output logic [CNT_W-1:0] trap_count,
  output logic             double_fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_REDIRECT,
    S_HANDLER,
    S_RETURN
  } state_e;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        fcnt_q, fcnt_d;
  logic [14:0]       sepc_d;
  logic [63:0]       scause_d;
  logic [CNT_W-1:0]  trap_count_q, trap_count_d;

  assign trap_count = trap_count_q;

  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    sepc_d        = sepc_q;
    scause_d      = scause_q;
    trap_count_d  = trap_count_q;
    flush         = 1'b0;
    pc_redirect   = 1'b0;
    redirect_addr = '0;
    in_trap       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (exception_in) begin
          sepc_d   = sepc_in;
          scause_d = scause_in;
          if (trap_count_q != '1) trap_count_d = trap_count_q + CNT_W'(1);
          fcnt_d   = FLUSH_LOAD;
          state_d  = S_FLUSH;
        end
      end
      S_FLUSH: begin
        flush   = 1'b1;
        in_trap = 1'b1;
        if (fcnt_q == '0) state_d = S_REDIRECT;
        else              fcnt_d  = fcnt_q - 4'd1;
      end
      S_REDIRECT: begin
        flush         = 1'b1;
        in_trap       = 1'b1;
        pc_redirect   = 1'b1;
        redirect_addr = TRAP_VECTOR;
        state_d       = S_HANDLER;
      end
      S_HANDLER: begin
        in_trap = 1'b1;
        if (sret) state_d = S_RETURN;
      end
      S_RETURN: begin
        flush         = 1'b1;
        in_trap       = 1'b1;
        pc_redirect   = 1'b1;
        redirect_addr = sepc_q + RETURN_OFFSET;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      fcnt_q       <= '0;
      sepc_q       <= '0;
      scause_q     <= '0;
      trap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      sepc_q       <= sepc_d;
      scause_q     <= scause_d;
      trap_count_q <= trap_count_d;
    end
  end

`ifdef TRAP_DOUBLE_FAULT_EN
  logic double_fault_q, double_fault_d;

  always_comb begin
    double_fault_d = double_fault_q;
    if (exception_in && (state_q == S_FLUSH || state_q == S_REDIRECT ||
                         state_q == S_HANDLER))
      double_fault_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) double_fault_q <= 1'b0;
    else       double_fault_q <= double_fault_d;
  end

  assign double_fault = double_fault_q;
`else
  assign double_fault = 1'b0;
`endif

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Sequences the pipeline response to a trap raised by the combinational exception detector: captures the faulting PC and cause into SEPC/SCAUSE registers, flushes the pipeline, redirects fetch to the trap vector, then returns on SRET.
- Sits between the exception detector (EXE stage) and the PC/pipeline-register control logic.
- Moore FSM; all control outputs are decoded from registered state.

Parameters:
- TRAP_VECTOR, 15'h1F00, fetch address of the trap handler.
- FLUSH_CYCLES, 2, number of cycles flush is held after a trap is accepted (legal range 1..15).
- RETURN_OFFSET, 4, added to the saved SEPC to form the SRET return address.
- CNT_W, 8, width of the trap counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- exception_in  input  1  trap request from the exception detector.
- sepc_in  input  15  faulting PC, valid while exception_in=1.
- scause_in  input  64  cause word, valid while exception_in=1.
- sret  input  1  SRET decoded in EXE.
- flush  output  1  clears the IF/ID/EXE pipeline registers.
- pc_redirect  output  1  PC mux select: load redirect_addr.
- redirect_addr  output  15  target PC while pc_redirect=1; otherwise 0.
- sepc_q  output  15  saved exception PC.
- scause_q  output  64  saved cause.
- in_trap  output  1  high from trap acceptance until the RETURN cycle completes.
- trap_count  output  CNT_W  number of accepted traps; saturating.
- double_fault  output  1  sticky nested-trap flag (see Optional Feature).

Behaviour:
- Reset (reset=1 at a rising edge): state=IDLE, flush counter=0, sepc_q=0, scause_q=0, trap_count=0, double_fault=0. Resulting outputs: flush=0, pc_redirect=0, redirect_addr=0, in_trap=0. Reset overrides every state, including mid-flush and mid-handler.
- States: IDLE, FLUSH, REDIRECT, HANDLER, RETURN.
- IDLE:
  - If exception_in=1 at an edge, latch sepc_in and scause_in, increment trap_count (saturates at all-ones), load the flush counter with FLUSH_CYCLES-1, and go to FLUSH.
  - sret is ignored in IDLE.
  - If exception_in and sret are both high, the exception wins.
- FLUSH: flush=1, in_trap=1. The counter decrements each cycle; when it reaches 0, go to REDIRECT. FLUSH lasts exactly FLUSH_CYCLES cycles.
- REDIRECT: one cycle; pc_redirect=1, redirect_addr=TRAP_VECTOR, flush=1, in_trap=1. Then go to HANDLER.
- HANDLER: in_trap=1, flush=0, pc_redirect=0.
  - sret=1 → go to RETURN.
  - exception_in does not recapture sepc_q/scause_q and does not increment trap_count.
- RETURN: one cycle; pc_redirect=1, redirect_addr=sepc_q+RETURN_OFFSET (15-bit, wraps modulo 2^15), flush=1, in_trap=1. Then go to IDLE.
  - exception_in during RETURN is ignored.
  - A new trap is accepted in the following IDLE cycle.
- sepc_q and scause_q hold their values after return until the next accepted trap.
- Latency: trap accepted at edge N → flush high in cycles N+1 .. N+FLUSH_CYCLES+1 (FLUSH plus REDIRECT) → pc_redirect high in cycle N+FLUSH_CYCLES+1.
- Inputs sepc_in and scause_in are sampled only on the acceptance edge.

Optional Feature:
- Macro: TRAP_DOUBLE_FAULT_EN.
- Defined: exception_in=1 in FLUSH, REDIRECT or HANDLER sets double_fault=1. The flag is sticky and cleared only by reset. All other behaviour is unchanged: no recapture, no count.
- Undefined: double_fault is tied to 0 and no logic is built for it.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then release → all outputs 0, state IDLE, trap_count=0.
- Basic trap: exception_in=1 for 1 cycle with sepc_in=15'h0040, scause_in=64'h2000_0000_0000_0009 (defaults) → flush=1 for 3 cycles; pc_redirect=1 with redirect_addr=15'h1F00 in the 3rd flush cycle; sepc_q=15'h0040; trap_count=1; in_trap=1.
- Return with wrap: trap with sepc_in=15'h7FFE, then sret=1 in HANDLER → one cycle with pc_redirect=1 and redirect_addr=15'h0002; back to IDLE; in_trap=0.
- Priority and nesting: exception_in and sret both high in IDLE → trap taken. A second exception_in in HANDLER with sepc_in=15'h0100 → sepc_q unchanged; trap_count unchanged; double_fault=1 only when TRAP_DOUBLE_FAULT_EN is defined.
- Reset mid-operation: assert reset during the 2nd FLUSH cycle → next cycle all outputs 0 and state IDLE; a subsequent exception is accepted normally.
- Counter saturation: with CNT_W=2, accept 5 trap/SRET sequences → trap_count stops at 3.
